// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver: turns a position command into hobby-servo PWM frames.
// Build macro SERVO_SLEW_EN limits the per-frame position step to SLEW_STEP.
module servo_pwm_driver #(
   parameter int CLK_HZ    = 25_000_000,
   parameter int PERIOD_US = 20000,
   parameter int MIN_US    = 1000,
   parameter int MAX_US    = 2000,
   parameter int POS_W     = 8,
   parameter int SLEW_STEP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [POS_W-1:0] x_position,
   input  logic             pos_valid,
   output logic             o_pwm,
   output logic             o_frame,
   output logic [POS_W-1:0] o_cur_pos
);

   localparam int DIV    = CLK_HZ / 1_000_000;
   localparam int PS_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int CNT_W  = $clog2(PERIOD_US + 1);
   localparam int SPAN   = MAX_US - MIN_US;
   localparam int PROD_W = POS_W + 11;
   localparam int TOP_W  =
      MIN_US + ((((1 << POS_W) - 1) * SPAN) >> POS_W);

   generate
      if (DIV < 1 ||
          (CLK_HZ % 1_000_000) != 0 ||
          SPAN <= 0 ||
          SPAN >= 2048 ||
          MIN_US < 1 ||
          SLEW_STEP < 0 ||
          TOP_W >= PERIOD_US) begin : g_cfg_err
         $error("servo_pwm_driver: bad configuration");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [PS_W-1:0]   ps;
   logic              us_tick;
   logic [CNT_W-1:0]  us_cnt;
   logic [CNT_W-1:0]  width_us;
   logic [CNT_W-1:0]  width_nx;
   logic [POS_W-1:0]  pending;
   logic [POS_W-1:0]  apply_pos;
   logic [PROD_W-1:0] prod;
   logic              frame_start;
   logic              last_hi;
   logic              last_frame;

   assign us_tick = (ps == PS_W'(DIV - 1));

   assign last_hi =
      us_tick && (us_cnt == width_us - CNT_W'(1));

   assign last_frame =
      us_tick && (us_cnt == CNT_W'(PERIOD_US - 1));

`ifdef SERVO_SLEW_EN
   localparam logic [POS_W-1:0] STEP = POS_W'(SLEW_STEP);

   // Step the driven position toward the pending one, landing exactly on it.
   always_comb begin
      apply_pos = pending;
      if (pending > o_cur_pos) begin
         if (pending - o_cur_pos > STEP)
            apply_pos = o_cur_pos + STEP;
      end else if (o_cur_pos - pending > STEP) begin
         apply_pos = o_cur_pos - STEP;
      end
   end
`else
   assign apply_pos = pending;
`endif

   assign prod =
      PROD_W'(apply_pos) * PROD_W'(SPAN);

   assign width_nx =
      CNT_W'(MIN_US) + CNT_W'(prod >> POS_W);

   // Frame sequencing; a frame start is the last IDLE or LOW cycle.
   always_comb begin
      state_nx    = state;
      frame_start = 1'b0;
      unique case (state)
         IDLE: begin
            frame_start = 1'b1;
            state_nx    = HIGH;
         end
         HIGH: begin
            if (last_hi)
               state_nx = LOW;
         end
         LOW: begin
            if (last_frame) begin
               frame_start = 1'b1;
               state_nx    = HIGH;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (rst) begin
         frame_start = 1'b0;
         state_nx    = IDLE;
      end
   end

   assign o_frame = frame_start;

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Microsecond prescaler, realigned to each frame start.
   always_ff @(posedge clk) begin
      if (rst || frame_start || us_tick)
         ps <= '0;
      else
         ps <= ps + PS_W'(1);
   end

   // Microseconds elapsed since the current frame started.
   always_ff @(posedge clk) begin
      if (rst || frame_start)
         us_cnt <= '0;
      else if (us_tick)
         us_cnt <= us_cnt + CNT_W'(1);
   end

   // Pending command capture and frame-boundary position latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending   <= '0;
         o_cur_pos <= '0;
         width_us  <= CNT_W'(MIN_US);
      end else begin
         if (pos_valid)
            pending <= x_position;
         if (frame_start) begin
            o_cur_pos <= apply_pos;
            width_us  <= width_nx;
         end
      end
   end

   // Registered pulse output, one clk behind the state.
   always_ff @(posedge clk) begin
      if (rst)
         o_pwm <= 1'b0;
      else
         o_pwm <= (state == HIGH);
   end

endmodule
